riscv_hazard_controller: RTL and testbench

RISCV_HAZARD_CONTROLLER -- requirements
Module: riscv_hazard_controller

---
 rtl/riscv_hazard_controller_if.sv | 43 ++++
 rtl/riscv_hazard_controller.sv | 119 +++++++++++
 tb/tb_riscv_hazard_controller.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_hazard_controller_if.sv
// Hazard-controller bundle: pipeline status coming into the controller and
// the per-stage stall/flush/MDU control going back out to the pipeline.
//   master : pipeline side (drives status, receives control)
//   slave  : controller side (receives status, drives control)
interface riscv_hazard_controller_if;
  // pipeline status
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  ex_rd_addr;
  logic        ex_mem_read;
  logic        ex_is_mdu;
  logic        mdu_done;
  logic        branch_taken;
  logic        mem_stall;
  // pipeline control
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_ex_stall;
  logic        ex_mem_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        mem_wb_flush;
  logic        mdu_start;
  logic        busy;
  logic [15:0] stall_cycles;

  modport master (
    output id_rs1_addr, id_rs2_addr, ex_rd_addr, ex_mem_read, ex_is_mdu,
           mdu_done, branch_taken, mem_stall,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           mdu_start, busy, stall_cycles
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, ex_rd_addr, ex_mem_read, ex_is_mdu,
           mdu_done, branch_taken, mem_stall,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           mdu_start, busy, stall_cycles
  );
endinterface

// File: rtl/riscv_hazard_controller.sv
// RISC-V pipeline hazard controller.
// Resolves, in priority order: memory freeze, MDU hold, MDU completion,
// taken branch flush, MDU launch and load-use stall. Stall/flush/mdu_start
// are combinational from state and inputs; busy follows the MDU_WAIT state.
// stall_cycles is a saturating count of cycles with pc_stall high.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (also forces all controls low)
//   hz  : hazard-controller interface, slave side
module riscv_hazard_controller (
  input  logic                      clk,
  input  logic                      rst,
  riscv_hazard_controller_if.slave  hz
);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  state_t      state;
  logic        done_pending;
  logic [15:0] stall_cnt;

  logic load_use;
  logic done_seen;
  logic pc_stall;
  logic if_id_stall;
  logic id_ex_stall;
  logic ex_mem_stall;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mem_wb_flush;
  logic mdu_start;

  assign load_use  = hz.ex_mem_read && (hz.ex_rd_addr != 5'd0) &&
                     ((hz.ex_rd_addr == hz.id_rs1_addr) ||
                      (hz.ex_rd_addr == hz.id_rs2_addr));
  // a done pulse swallowed by a freeze is remembered in done_pending
  assign done_seen = hz.mdu_done || done_pending;

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    mdu_start    = 1'b0;
    if (!rst) begin
      if (hz.mem_stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (state == MDU_WAIT) begin
        if (!done_seen) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_flush = 1'b1;
        end
        // on completion every control stays low so EX/MEM takes the result
      end else if (hz.branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (hz.ex_is_mdu) begin
        mdu_start    = 1'b1;
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      done_pending <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      if (pc_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;
      if (hz.mem_stall) begin
        if ((state == MDU_WAIT) && hz.mdu_done)
          done_pending <= 1'b1;
      end else if (state == MDU_WAIT) begin
        if (done_seen) begin
          state        <= RUN;
          done_pending <= 1'b0;
        end
      end else if (!hz.branch_taken && hz.ex_is_mdu) begin
        state <= MDU_WAIT;
      end
    end
  end

  assign hz.pc_stall     = pc_stall;
  assign hz.if_id_stall  = if_id_stall;
  assign hz.id_ex_stall  = id_ex_stall;
  assign hz.ex_mem_stall = ex_mem_stall;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.mem_wb_flush = mem_wb_flush;
  assign hz.mdu_start    = mdu_start;
  assign hz.busy         = (state == MDU_WAIT) && !rst;
  assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_riscv_hazard_controller.sv
// Testbench for riscv_hazard_controller: directed scenarios plus randomized
// traffic, all compared against a rule-table reference model.
module tb_riscv_hazard_controller;

  logic clk;
  logic rst;
  riscv_hazard_controller_if hz ();

  riscv_hazard_controller dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // control vector order:
  // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
  //  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mdu_start}
  localparam logic [8:0] C_NONE    = 9'b0000_0000_0;
  localparam logic [8:0] C_FREEZE  = 9'b1111_0001_0;
  localparam logic [8:0] C_HOLD    = 9'b1110_0010_0;
  localparam logic [8:0] C_LAUNCH  = 9'b1110_0010_1;
  localparam logic [8:0] C_BRANCH  = 9'b0000_1100_0;
  localparam logic [8:0] C_LOADUSE = 9'b1100_0100_0;

  int n_checks;
  int n_fail;

  // reference model state: is an MDU op outstanding, was its done seen, count
  bit m_in_flight;
  bit m_done_seen;
  int m_cnt;

  logic [8:0]  obs_ctl;
  logic        obs_busy;
  logic [15:0] obs_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit mr, input bit mdu,
                        input bit done, input bit br, input bit ms);
    rst             = r;
    hz.id_rs1_addr  = rs1;
    hz.id_rs2_addr  = rs2;
    hz.ex_rd_addr   = rd;
    hz.ex_mem_read  = mr;
    hz.ex_is_mdu    = mdu;
    hz.mdu_done     = done;
    hz.branch_taken = br;
    hz.mem_stall    = ms;
  endtask

  task automatic idle();
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  // One clock: inputs already driven; sample controls mid-cycle, advance the
  // model at the edge, then sample the counter just after the edge.
  task automatic cycle(input bit chk, input string tag);
    logic [8:0] exp_ctl;
    bit exp_busy;
    bit lu;
    #3;
    lu = hz.ex_mem_read && (hz.ex_rd_addr != 0) &&
         (hz.ex_rd_addr == hz.id_rs1_addr || hz.ex_rd_addr == hz.id_rs2_addr);
    exp_busy = !rst && m_in_flight;
    if (rst)                                     exp_ctl = C_NONE;
    else if (hz.mem_stall)                       exp_ctl = C_FREEZE;
    else if (m_in_flight && !(hz.mdu_done || m_done_seen)) exp_ctl = C_HOLD;
    else if (m_in_flight)                        exp_ctl = C_NONE;
    else if (hz.branch_taken)                    exp_ctl = C_BRANCH;
    else if (hz.ex_is_mdu)                       exp_ctl = C_LAUNCH;
    else if (lu)                                 exp_ctl = C_LOADUSE;
    else                                         exp_ctl = C_NONE;
    obs_ctl  = {hz.pc_stall, hz.if_id_stall, hz.id_ex_stall, hz.ex_mem_stall,
                hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.mem_wb_flush,
                hz.mdu_start};
    obs_busy = hz.busy;
    if (chk) begin
      check_eq({tag, "_ctl"}, 32'(obs_ctl), 32'(exp_ctl));
      check_eq({tag, "_busy"}, 32'(obs_busy), 32'(exp_busy));
    end
    @(posedge clk);
    if (rst) begin
      m_in_flight = 0;
      m_done_seen = 0;
      m_cnt       = 0;
    end else begin
      if (exp_ctl[8] && m_cnt < 65535) m_cnt++;
      if (hz.mem_stall) begin
        if (m_in_flight && hz.mdu_done) m_done_seen = 1;
      end else if (m_in_flight) begin
        if (hz.mdu_done || m_done_seen) begin
          m_in_flight = 0;
          m_done_seen = 0;
        end
      end else if (!hz.branch_taken && hz.ex_is_mdu) begin
        m_in_flight = 1;
      end
    end
    #1;
    obs_cnt = hz.stall_cycles;
    if (chk) check_eq({tag, "_cnt"}, 32'(obs_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    set_in(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    cycle(1, "reset");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_in_flight = 0;
    m_done_seen = 0;
    m_cnt       = 0;

    // reset must win over every active input
    set_in(1, 5'd3, 5'd3, 5'd3, 1, 1, 1, 1, 1);
    cycle(1, "rst_forced");
    check_eq("rst_ctl_zero", 32'(obs_ctl), 32'(C_NONE));
    check_eq("rst_cnt_zero", 32'(obs_cnt), 32'd0);

    // load-use on rs2, then x0 never stalls
    do_reset();
    set_in(0, 5'd1, 5'd5, 5'd5, 1, 0, 0, 0, 0);
    cycle(1, "lu");
    check_eq("lu_ctl", 32'(obs_ctl), 32'(C_LOADUSE));
    check_eq("lu_cnt", 32'(obs_cnt), 32'd1);
    idle();
    cycle(1, "lu_after");
    check_eq("lu_one_cycle", 32'(obs_ctl), 32'(C_NONE));
    set_in(0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);
    cycle(1, "lu_x0");
    check_eq("lu_x0_ctl", 32'(obs_ctl), 32'(C_NONE));

    // branch beats load-use
    set_in(0, 5'd7, 5'd2, 5'd7, 1, 0, 0, 1, 0);
    cycle(1, "br_lu");
    check_eq("br_lu_ctl", 32'(obs_ctl), 32'(C_BRANCH));

    // MDU launch at cycle 0, done at cycle 4
    do_reset();
    for (int unsigned c = 0; c < 6; c++) begin
      set_in(0, 5'd0, 5'd0, 5'd0, 0, (c < 5), (c == 4), 0, 0);
      cycle(1, "mdu");
      case (c)
        0: check_eq("mdu_c0", 32'({obs_ctl, obs_busy}), 32'({C_LAUNCH, 1'b0}));
        1, 2, 3: check_eq("mdu_hold", 32'({obs_ctl, obs_busy}), 32'({C_HOLD, 1'b1}));
        4: check_eq("mdu_c4", 32'({obs_ctl, obs_busy}), 32'({C_NONE, 1'b1}));
        default: check_eq("mdu_c5_busy", 32'(obs_busy), 32'd0);
      endcase
    end
    check_eq("mdu_cnt", 32'(obs_cnt), 32'd4);

    // done arrives under a freeze and is picked up afterwards
    do_reset();
    for (int unsigned c = 0; c < 5; c++) begin
      set_in(0, 5'd0, 5'd0, 5'd0, 0, (c == 0), (c == 2), 0, (c == 2));
      cycle(1, "dpend");
      if (c == 2) check_eq("dpend_freeze", 32'({obs_ctl, obs_busy}), 32'({C_FREEZE, 1'b1}));
      if (c == 3) check_eq("dpend_done", 32'({obs_ctl, obs_busy}), 32'({C_NONE, 1'b1}));
      if (c == 4) check_eq("dpend_run", 32'(obs_busy), 32'd0);
    end

    // reset abandons an in-flight MDU op
    do_reset();
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0);
    cycle(1, "abort_launch");
    idle();
    cycle(1, "abort_hold");
    rst = 1;
    cycle(1, "abort_rst");
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    cycle(1, "abort_done");
    check_eq("abort_ctl", 32'({obs_ctl, obs_busy}), 32'({C_NONE, 1'b0}));
    check_eq("abort_cnt", 32'(obs_cnt), 32'd0);

    // randomized traffic with small register numbers to provoke matches
    do_reset();
    for (int unsigned i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 49) == 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      cycle(1, "rand");
    end

    // counter saturation
    do_reset();
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    for (int unsigned i = 0; i < 70000; i++) cycle(0, "sat");
    check_eq("sat_cnt", 32'(obs_cnt), 32'hFFFF);
    cycle(1, "sat_hold");
    check_eq("sat_no_wrap", 32'(obs_cnt), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
